forward_source_tracker: RTL and testbench
=========================================

Name: forward_source_tracker

Overview:
- Keeps the in-flight register writes of the EX/MEM, MEM/WB and WB-retired stages as three ordered slots.
- Drives the destination-index and data inputs of the hazard/forward unit for both rs1 and rs2 instances. Slot 1 is the youngest and is matched first.
- Replaces pending load data when the load completes in MEM.
- Flags load-use hazards so the pipeline controller can insert a bubble.

Parameters:
- XLEN, 32, data width of forwarded values.
- REG_ADDR, 5, register index width.

Ports:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears all slots.
- stall  input  1  global hold; all slots keep their contents.
- flush  input  1  kills the EX entry being captured this cycle.
- ex_valid  input  1  EX stage holds a valid instruction to capture.
- ex_write_enable  input  1  EX instruction writes the register file.
- ex_is_load  input  1  EX instruction is a load; its result is not yet known.
- ex_rd  input  REG_ADDR  EX destination index.
- ex_result  input  XLEN  EX ALU result; ignored for loads.
- mem_load_data  input  XLEN  load data produced in MEM for the slot-1 entry.
- dec_rs1, dec_rs2  input  REG_ADDR  source indexes of the instruction in decode.
- destination_index_1/2/3  output  REG_ADDR  slot indexes; 0 when the slot is empty.
- data_1/2/3  output  XLEN  slot data; 0 when the slot is empty.
- load_use_hazard  output  1  decode must stall one cycle.
- hazard_count  output  32  load-use stall-cycle counter (optional feature).

Behaviour:
- Reset: every slot is invalid. All destination_index_n = 0, data_n = 0, load_use_hazard = 0, hazard_count = 0, all visible the cycle after the reset edge.
- Reset during operation discards all in-flight entries regardless of stall/flush.
- Capture condition: ex_valid & ex_write_enable & ex_rd != 0 & !flush. A captured entry is valid; any other entry is a bubble (invalid).
- Per-edge priority: reset > stall > advance.
- Advance (stall = 0):
  - slot3 <= slot2.
  - slot2 <= slot1. If slot1 is a pending load, slot2 data = mem_load_data and pending is cleared.
  - slot1 <= captured EX entry or bubble. Data = ex_result; pending = ex_is_load.
- Stall = 1: all slots, including pending flags, hold. flush is ignored that cycle. The instruction stays in EX and flush is re-sampled later.
- Latency: an EX result is visible on destination_index_1/data_1 one cycle after capture, on _2 after two cycles and on _3 after three. All three outputs are registered.
- Empty slot presentation: index 0 with data 0. A source x0 therefore matches and forwards 0, which is architecturally correct, so no valid bit is needed downstream.
- Pending load in slot1: data_1 = 0 (don't-care). Decode must not consume it.
- load_use_hazard, combinational: slot1 valid & pending & slot1.rd != 0 & (slot1.rd == dec_rs1 | slot1.rd == dec_rs2).
  - The controller responds with ex_valid = 0 next edge.
  - The load then advances to slot2 with real data, and the hazard clears.
- Duplicate rd across slots is allowed. Ordering guarantees the youngest value wins through slot-1-first matching.
- The write/read of the same register in the WB cycle is covered by slot3. The register file need not bypass.

Optional Feature:
- Macro: FORWARD_TRACKER_PERF_EN.
- Enabled: hazard_count increments by 1 on every cycle with load_use_hazard = 1 and reset = 0. It saturates at 32'hFFFF_FFFF and clears only on reset.
- Disabled: hazard_count is tied to 0 and no counter flops are inferred.

Test Plan:
- Reset with all slots loaded from prior traffic -> next cycle all indexes and data = 0 and load_use_hazard = 0.
- Capture ADD x5 = 32'h0000_0011 -> destination_index_1 = 5, data_1 = 0x11. Two cycles later destination_index_3 = 5, then slot 3 empties.
- Load x7 in slot1 with dec_rs2 = 7 -> load_use_hazard = 1. Bubble inserted with mem_load_data = 32'hDEAD_BEEF -> next cycle destination_index_2 = 7, data_2 = 0xDEADBEEF, hazard = 0.
- Writes to x3 on consecutive cycles with 0xA, 0xB, 0xC -> slots 1/2/3 = x3 with data 0xC/0xB/0xA.
- stall = 1 for 3 cycles with flush = 1 -> slots unchanged. Then stall = 0, flush = 1, ex_rd = 9 -> slot1 empty and the other slots shift.
- ex_rd = 0 write -> slot1 index 0, data 0. With FORWARD_TRACKER_PERF_EN, 4 hazard cycles -> hazard_count = 4.

Source files
------------

// File: rtl/forward_source_tracker.sv
// rtl/forward_source_tracker.sv - three-slot in-flight register write tracker feeding the rs1/rs2 forward units
//
// Optional feature macro: FORWARD_TRACKER_PERF_EN (load-use stall-cycle counter on hazard_count).
//
// Slot 1 holds the EX/MEM entry, slot 2 the MEM/WB entry and slot 3 the
// WB-retired entry. An invalid slot always stores index 0 and data 0, so the
// slot registers drive the outputs directly and an empty slot looks like x0.

module forward_source_tracker #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic                ex_write_enable,
  input  logic                ex_is_load,
  input  logic [REG_ADDR-1:0] ex_rd,
  input  logic [XLEN-1:0]     ex_result,
  input  logic [XLEN-1:0]     mem_load_data,
  input  logic [REG_ADDR-1:0] dec_rs1,
  input  logic [REG_ADDR-1:0] dec_rs2,
  output logic [REG_ADDR-1:0] destination_index_1,
  output logic [REG_ADDR-1:0] destination_index_2,
  output logic [REG_ADDR-1:0] destination_index_3,
  output logic [XLEN-1:0]     data_1,
  output logic [XLEN-1:0]     data_2,
  output logic [XLEN-1:0]     data_3,
  output logic                load_use_hazard,
  output logic [31:0]         hazard_count
);

  typedef struct packed {
    logic                valid;
    logic                pending;
    logic [REG_ADDR-1:0] rd;
    logic [XLEN-1:0]     data;
  } slot_t;

  slot_t slot1_q;
  slot_t slot2_q;
  slot_t slot3_q;

  logic  capture;
  slot_t ex_entry;
  slot_t slot1_retired;

  // Build the entry entering slot 1; loads carry zero data until MEM supplies it.
  always_comb begin
    capture  = ex_valid & ex_write_enable & (ex_rd != '0) & ~flush;
    ex_entry = '0;
    if (capture) begin
      ex_entry.valid   = 1'b1;
      ex_entry.pending = ex_is_load;
      ex_entry.rd      = ex_rd;
      ex_entry.data    = ex_is_load ? '0 : ex_result;
    end
  end

  // Slot 1 moving to slot 2: a pending load picks up its data from MEM here.
  always_comb begin
    slot1_retired = slot1_q;
    if (slot1_q.valid && slot1_q.pending) begin
      slot1_retired.data    = mem_load_data;
      slot1_retired.pending = 1'b0;
    end
  end

  // Slot pipeline: reset clears, stall holds everything, otherwise shift one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot1_q <= '0;
      slot2_q <= '0;
      slot3_q <= '0;
    end else if (!stall) begin
      slot3_q <= slot2_q;
      slot2_q <= slot1_retired;
      slot1_q <= ex_entry;
    end
  end

  assign destination_index_1 = slot1_q.rd;
  assign destination_index_2 = slot2_q.rd;
  assign destination_index_3 = slot3_q.rd;
  assign data_1              = slot1_q.data;
  assign data_2              = slot2_q.data;
  assign data_3              = slot3_q.data;

  // A source in decode that needs a load still waiting in slot 1 must bubble.
  assign load_use_hazard = slot1_q.valid & slot1_q.pending & (slot1_q.rd != '0) &
                           ((slot1_q.rd == dec_rs1) | (slot1_q.rd == dec_rs2));

`ifdef FORWARD_TRACKER_PERF_EN
  logic [31:0] hazard_count_q;

  // Saturating count of load-use stall cycles, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hazard_count_q <= '0;
    end else if (load_use_hazard && (hazard_count_q != 32'hFFFF_FFFF)) begin
      hazard_count_q <= hazard_count_q + 32'd1;
    end
  end

  assign hazard_count = hazard_count_q;
`else
  assign hazard_count = '0;
`endif

endmodule

// File: tb/tb_forward_source_tracker.sv
// tb/tb_forward_source_tracker.sv - table-driven and modelled random checks for forward_source_tracker

module tb_forward_source_tracker;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic        ex_write_enable;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [31:0] mem_load_data;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  destination_index_1;
  logic [4:0]  destination_index_2;
  logic [4:0]  destination_index_3;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic [31:0] data_3;
  logic        load_use_hazard;
  logic [31:0] hazard_count;

  forward_source_tracker #(.XLEN(32), .REG_ADDR(5)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .flush               (flush),
    .ex_valid            (ex_valid),
    .ex_write_enable     (ex_write_enable),
    .ex_is_load          (ex_is_load),
    .ex_rd               (ex_rd),
    .ex_result           (ex_result),
    .mem_load_data       (mem_load_data),
    .dec_rs1             (dec_rs1),
    .dec_rs2             (dec_rs2),
    .destination_index_1 (destination_index_1),
    .destination_index_2 (destination_index_2),
    .destination_index_3 (destination_index_3),
    .data_1              (data_1),
    .data_2              (data_2),
    .data_3              (data_3),
    .load_use_hazard     (load_use_hazard),
    .hazard_count        (hazard_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, fl, vl, we, ld;
    logic [4:0]  rd;
    logic [31:0] res, mld;
    logic [4:0]  rs1, rs2;
    logic [4:0]  e1, e2, e3;
    logic [31:0] d1, d2, d3;
    logic        p1;
  } vec_t;

  typedef struct {
    int          id;
    logic [4:0]  i1, i2, i3;
    logic [31:0] d1, d2, d3;
    logic        haz;
    logic [31:0] hc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bench-side count of expected load-use stall cycles.
  logic [31:0] cnt;
  logic [4:0]  prev_e1;
  logic        prev_p1;

  // Reference slots for the random phase.
  logic        m_v[1:3];
  logic        m_p[1:3];
  logic [4:0]  m_rd[1:3];
  logic [31:0] m_d[1:3];

  function automatic vec_t mk(input logic rst, st, fl, vl, we, ld, input logic [4:0] rd,
                              input logic [31:0] res, mld, input logic [4:0] rs1, rs2,
                              input logic [4:0] e1, e2, e3, input logic [31:0] d1, d2, d3,
                              input logic p1);
    vec_t v;
    v.rst = rst; v.st = st; v.fl = fl; v.vl = vl; v.we = we; v.ld = ld;
    v.rd = rd; v.res = res; v.mld = mld; v.rs1 = rs1; v.rs2 = rs2;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.p1 = p1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.st; flush = v.fl; ex_valid = v.vl; ex_write_enable = v.we;
    ex_is_load = v.ld; ex_rd = v.rd; ex_result = v.res; mem_load_data = v.mld;
    dec_rs1 = v.rs1; dec_rs2 = v.rs2;
  endtask

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL step%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk(e.id, "idx1", {27'd0, destination_index_1}, {27'd0, e.i1});
    chk(e.id, "idx2", {27'd0, destination_index_2}, {27'd0, e.i2});
    chk(e.id, "idx3", {27'd0, destination_index_3}, {27'd0, e.i3});
    chk(e.id, "data1", data_1, e.d1);
    chk(e.id, "data2", data_2, e.d2);
    chk(e.id, "data3", data_3, e.d3);
    chk(e.id, "hazard", {31'd0, load_use_hazard}, {31'd0, e.haz});
    chk(e.id, "hazard_count", hazard_count, e.hc);
  endtask

  function automatic logic [31:0] exp_hc();
`ifdef FORWARD_TRACKER_PERF_EN
    return cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Count the stall cycle seen before this edge, then advance the bench copy of slot 1.
  task automatic count_hazard(input logic rst, input logic [4:0] rs1, rs2,
                              input logic [4:0] new_e1, input logic new_p1);
    if (rst) cnt = 32'd0;
    else if (prev_p1 && prev_e1 != 5'd0 && (prev_e1 == rs1 || prev_e1 == rs2) && cnt != 32'hFFFF_FFFF)
      cnt = cnt + 32'd1;
    prev_e1 = new_e1;
    prev_p1 = new_p1;
  endtask

  task automatic model_step(input vec_t v);
    logic cap;
    cap = v.vl && v.we && v.rd != 5'd0 && !v.fl;
    if (v.rst) begin
      for (int k = 1; k <= 3; k++) begin
        m_v[k] = 1'b0; m_p[k] = 1'b0; m_rd[k] = 5'd0; m_d[k] = 32'd0;
      end
    end else if (!v.st) begin
      m_v[3] = m_v[2]; m_p[3] = m_p[2]; m_rd[3] = m_rd[2]; m_d[3] = m_d[2];
      m_v[2] = m_v[1]; m_rd[2] = m_rd[1];
      m_d[2] = (m_v[1] && m_p[1]) ? v.mld : m_d[1];
      m_p[2] = 1'b0;
      m_v[1] = cap; m_p[1] = cap && v.ld; m_rd[1] = v.rd; m_d[1] = v.res;
    end
  endtask

  function automatic logic [4:0] m_idx(input int k);
    return m_v[k] ? m_rd[k] : 5'd0;
  endfunction

  function automatic logic [31:0] m_dat(input int k);
    return (m_v[k] && !m_p[k]) ? m_d[k] : 32'd0;
  endfunction

  initial begin
    exp_t e;
    vec_t v;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_write_enable = 1'b0;
    ex_is_load = 1'b0; ex_rd = 5'd0; ex_result = 32'd0; mem_load_data = 32'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    cnt = 32'd0; prev_e1 = 5'd0; prev_p1 = 1'b0;

    //                rst st fl vl we ld rd   res            mld             rs1   rs2    e1    e2    e3    d1      d2             d3             p1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 32'h0,         32'h0,          5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd5, 32'h11,        32'h0,          5'd0, 5'd0,  5'd5, 5'd0, 5'd0, 32'h11, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 32'h0,         32'h0,          5'd0, 5'd0,  5'd0, 5'd5, 5'd0, 32'h0,  32'h11,        32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 32'h0,         32'h0,          5'd0, 5'd0,  5'd0, 5'd0, 5'd5, 32'h0,  32'h0,         32'h11,        0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 32'h0,         32'h0,          5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 5'd7, 32'h1234,      32'h0,          5'd0, 5'd7,  5'd7, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 32'h0,         32'hDEAD_BEEF,  5'd0, 5'd7,  5'd0, 5'd7, 5'd0, 32'h0,  32'hDEAD_BEEF, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd3, 32'hA,         32'h0,          5'd0, 5'd0,  5'd3, 5'd0, 5'd7, 32'hA,  32'h0,         32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd3, 32'hB,         32'h0,          5'd0, 5'd0,  5'd3, 5'd3, 5'd0, 32'hB,  32'hA,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd3, 32'hC,         32'h0,          5'd0, 5'd0,  5'd3, 5'd3, 5'd3, 32'hC,  32'hB,         32'hA,         0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 1, 1, 1, 0, 5'd9, 32'h99,      32'h0,          5'd0, 5'd0,  5'd3, 5'd3, 5'd3, 32'hC,  32'hB,         32'hA,         0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 5'd9, 32'h99,        32'h0,          5'd0, 5'd0,  5'd0, 5'd3, 5'd3, 32'h0,  32'hC,         32'hB,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd0, 32'h55,        32'h0,          5'd0, 5'd0,  5'd0, 5'd0, 5'd3, 32'h0,  32'h0,         32'hC,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 5'd8, 32'h1234,      32'h0,          5'd8, 5'd0,  5'd8, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5'd0, 32'h0,       32'h0,          5'd8, 5'd0,  5'd8, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 32'h0,         32'hCAFE_F00D,  5'd8, 5'd0,  5'd0, 5'd8, 5'd0, 32'h0,  32'hCAFE_F00D, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd8, 32'h77,        32'h0,          5'd8, 5'd0,  5'd8, 5'd0, 5'd8, 32'h77, 32'h0,         32'hCAFE_F00D, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd4, 32'h44,        32'h0,          5'd0, 5'd0,  5'd4, 5'd8, 5'd0, 32'h44, 32'h77,        32'h0,         0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 5'd6, 32'h66,        32'h0,          5'd4, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 5'd6, 32'h66,        32'h0,          5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'd6, 32'h66,        32'h0,          5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 5'd2, 32'h1234,      32'h0,          5'd2, 5'd2,  5'd2, 5'd0, 5'd0, 32'h0,  32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 5'd2, 32'h22,        32'h2222,       5'd2, 5'd0,  5'd2, 5'd2, 5'd0, 32'h22, 32'h2222,      32'h0,         0));

    // Directed table: expectations come from the table, hazard from the expected slot-1 state.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v);
      count_hazard(v.rst, v.rs1, v.rs2, v.e1, v.p1);
      e.id = i; e.i1 = v.e1; e.i2 = v.e2; e.i3 = v.e3;
      e.d1 = v.d1; e.d2 = v.d2; e.d3 = v.d3;
      e.haz = v.p1 && v.e1 != 5'd0 && (v.e1 == v.rs1 || v.e1 == v.rs2);
      e.hc = exp_hc();
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_outputs();
    end

    // Random traffic against the reference slots, starting from a reset.
    for (int i = 0; i < 300; i++) begin
      v = mk(i == 0 || $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
             5'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      drive(v);
      model_step(v);
      count_hazard(v.rst, v.rs1, v.rs2, m_idx(1), m_v[1] && m_p[1]);
      e.id = 1000 + i; e.i1 = m_idx(1); e.i2 = m_idx(2); e.i3 = m_idx(3);
      e.d1 = m_dat(1); e.d2 = m_dat(2); e.d3 = m_dat(3);
      e.haz = m_v[1] && m_p[1] && m_rd[1] != 5'd0 && (m_rd[1] == v.rs1 || m_rd[1] == v.rs2);
      e.hc = exp_hc();
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_outputs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
